// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receiver with 16x oversampled bit recovery and valid/ready output.
//   clk, arst_n                 clock, asynchronous active-low reset
//   baud_div                    one sample tick every baud_div+1 clocks
//   num_data, parity, stop_2    frame format: 5+num_data bits, even parity, two stop bits
//   rxd                         serial input, idle high, asynchronous to clk
//   rx_data, rx_valid, rx_ready received character and its handshake
//   parity_err, frame_err       error flags for the presented character
//   overrun                     one-clock pulse when a completed frame is dropped
//   busy                        receiver is inside a frame
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 majority of the last three ticks.
module uart_rx_fsm #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       num_data,
    input  logic             parity,
    input  logic             stop_2,
    input  logic             rxd,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP_1, STOP_2} state_t;

    state_t           state;
    logic [2:0]       sync;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       phase;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [1:0]       cfg_nd;
    logic             cfg_par;
    logic             cfg_stop2;
    logic             perr;
    logic             ferr;
    logic             cmp;
    logic             tick;
    logic             fall;
    logic             mid;
    logic             bit_v;

    assign tick = div_cnt == baud_div;
    assign fall = sync[2] & ~sync[1];
    assign mid  = tick && phase == LAST;
    assign busy = state != IDLE;

`ifdef UART_RX_MAJORITY_EN
    // Samples from the two ticks preceding the decision tick.
    logic [1:0] smp;
    assign bit_v = (smp[1] & smp[0]) | (smp[1] & sync[1]) | (smp[0] & sync[1]);
`else
    assign bit_v = sync[1];
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            sync       <= 3'b111;
            div_cnt    <= '0;
            phase      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            cfg_nd     <= '0;
            cfg_par    <= 1'b0;
            cfg_stop2  <= 1'b0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            cmp        <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            smp        <= '0;
`endif
        end else begin
            sync    <= {sync[1:0], rxd};
            overrun <= 1'b0;
            cmp     <= 1'b0;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                phase <= phase + 1'b1;
`ifdef UART_RX_MAJORITY_EN
            if (tick)
                smp <= {smp[0], sync[1]};
`endif
            // A completion may land in the same cycle as a handshake; new data wins.
            if (cmp) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= perr;
                    frame_err  <= ferr;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: if (fall) begin
                    state   <= START;
                    div_cnt <= '0;
                    phase   <= '0;
                end
                START: if (tick && phase == MID) begin
                    if (bit_v) begin
                        state <= IDLE;
                    end else begin
                        state     <= DATA;
                        phase     <= '0;
                        bit_cnt   <= '0;
                        shreg     <= '0;
                        perr      <= 1'b0;
                        ferr      <= 1'b0;
                        cfg_nd    <= num_data;
                        cfg_par   <= parity;
                        cfg_stop2 <= stop_2;
                    end
                end
                DATA: if (mid) begin
                    shreg[bit_cnt] <= bit_v;
                    bit_cnt        <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd4 + {1'b0, cfg_nd})
                        state <= cfg_par ? PARITY : STOP_1;
                end
                PARITY: if (mid) begin
                    perr  <= (^shreg) ^ bit_v;
                    state <= STOP_1;
                end
                STOP_1: if (mid) begin
                    ferr  <= ferr | ~bit_v;
                    state <= cfg_stop2 ? STOP_2 : IDLE;
                    cmp   <= ~cfg_stop2;
                end
                STOP_2: if (mid) begin
                    ferr  <= ferr | ~bit_v;
                    state <= IDLE;
                    cmp   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: randomized and directed frames against a frame-level receive model.
module tb_uart_rx_fsm;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [15:0] baud_div = 16'd3;
    logic [1:0]  num_data = 2'd3;
    logic        parity = 1'b0;
    logic        stop_2 = 1'b0;
    logic        rxd = 1'b1;
    logic        rx_ready = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ov_cnt = 0;
    int   ov0;
    int   wk;
    logic prev_hs = 1'b0;

    uart_rx_fsm dut (
        .clk(clk), .arst_n(arst_n), .baud_div(baud_div), .num_data(num_data),
        .parity(parity), .stop_2(stop_2), .rxd(rxd), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (overrun)
            ov_cnt++;
        if (rx_valid && rx_ready) begin
            check("valid_1clk", 32'(prev_hs), 0);
            check("char_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.d));
                check("parity_err", 32'(parity_err), 32'(e.pe));
                check("frame_err", 32'(frame_err), 32'(e.fe));
            end
        end
        prev_hs = rx_valid && rx_ready;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        rxd = v;
        cyc(n);
    endtask

    task automatic expect_char(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d;
        e.pe = pe;
        e.fe = fe;
        exp_q.push_back(e);
    endtask

    // Model: a frame yields its masked data, a parity error only when parity is on and
    // the sent bit was wrong, and a frame error when any transmitted stop bit was low.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] nd, input logic par,
                              input logic s2, input logic bad_par, input logic [1:0] stop_lo,
                              input logic expect_it);
        int t;
        int nb;
        logic [7:0] dm;
        t = 16 * (int'(baud_div) + 1);
        nb = 5 + int'(nd);
        dm = d & 8'((1 << nb) - 1);
        if (expect_it)
            expect_char(dm, par & bad_par, stop_lo[0] | (s2 & stop_lo[1]));
        num_data = nd;
        parity = par;
        stop_2 = s2;
        drive(1'b0, t);
        num_data = 2'($urandom);
        parity = 1'($urandom);
        stop_2 = 1'($urandom);
        for (int i = 0; i < nb; i++)
            drive(dm[i], t);
        if (par)
            drive((^dm) ^ bad_par, t);
        drive(~stop_lo[0], t);
        if (s2)
            drive(~stop_lo[1], t);
    endtask

    task automatic gap(input int bits);
        drive(1'b1, bits * 16 * (int'(baud_div) + 1));
        check("busy_idle", 32'(busy), 0);
        check("drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc(3);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        arst_n = 1'b1;
        cyc(2);

        send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        gap(1);

        send_frame(8'h13, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        gap(1);
        send_frame(8'h13, 2'd0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
        gap(1);

        send_frame(8'h3C, 2'd3, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1);
        drive(1'b0, 3 * 64);
        check("ferr_line_low_busy", 32'(busy), 0);
        check("ferr_line_low_drained", 32'(exp_q.size()), 0);
        gap(1);
        send_frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        gap(1);

        rxd = 1'b0;
        cyc(8);
        check("false_start_busy", 32'(busy), 1);
        cyc(8);
        rxd = 1'b1;
        cyc(40);
        check("false_start_idle", 32'(busy), 0);
        gap(1);

        rx_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        gap(1);
        check("ovr_first_valid", 32'(rx_valid), 1);
        check("ovr_first_data", 32'(rx_data), 32'h11);
        send_frame(8'h22, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        gap(1);
        check("ovr_kept_data", 32'(rx_data), 32'h11);
        check("ovr_kept_valid", 32'(rx_valid), 1);
        check("ovr_pulses", 32'(ov_cnt - ov0), 1);
        expect_char(8'h11, 1'b0, 1'b0);
        rx_ready = 1'b1;
        cyc(3);
        check("ovr_drain", 32'(exp_q.size()), 0);
        check("ovr_valid_low", 32'(rx_valid), 0);

        rx_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        gap(1);
        check("coin_first_data", 32'(rx_data), 32'h5A);
        fork
            send_frame(8'h96, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
            begin
                wk = 0;
                while (!busy && wk < 5000) begin
                    @(negedge clk);
                    wk++;
                end
                while (busy && wk < 5000) begin
                    @(negedge clk);
                    wk++;
                end
                check("coin_wait", 32'(wk < 5000), 1);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        check("coin_valid", 32'(rx_valid), 1);
        check("coin_data", 32'(rx_data), 32'h96);
        check("coin_no_overrun", 32'(ov_cnt - ov0), 0);
        expect_char(8'h96, 1'b0, 1'b0);
        rx_ready = 1'b1;
        cyc(3);
        check("coin_drain", 32'(exp_q.size()), 0);
        gap(1);

        ov0 = ov_cnt;
        num_data = 2'd3;
        parity = 1'b0;
        stop_2 = 1'b0;
        drive(1'b0, 64);
        drive(1'b1, 64);
        drive(1'b0, 64);
        rxd = 1'b1;
        cyc(32);
        arst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_valid", 32'(rx_valid), 0);
        cyc(4);
        arst_n = 1'b1;
        cyc(2);
        gap(1);
        send_frame(8'h0F, 2'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        gap(1);
        check("rst_mid_no_overrun", 32'(ov_cnt - ov0), 0);

        for (int f = 0; f < 30; f++) begin
            baud_div = 16'($urandom_range(0, 2));
            send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 3) == 0,
                       ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'b1);
            gap(1 + $urandom_range(0, 1));
        end

        check("overrun_total", 32'(ov_cnt), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
